// File: rtl/inv_bus_pkg.sv
// Shared definitions for the inverted single-wire bus (receiver and transmitter).
package inv_bus_pkg;

    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 16;

    localparam logic BUS_IDLE  = 1'b1;
    localparam logic BUS_START = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/inv_bus_rx_bit_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inv_bus_rx.sv
// Receiver for the inverted tri-state serial bus: oversampled framing,
// bit re-inversion and a single-entry valid/ready holding register.
module inv_bus_rx
    import inv_bus_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              BusLine,
    output logic [DATA_W-1:0] Data,
    output logic              Valid,
    input  logic              Ready,
    output logic              FrameErr,
    output logic              Overrun,
    output logic              Busy
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(DATA_W - 1);

    logic              line_s;
    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [BIDX_W-1:0] bit_idx;
    logic [DATA_W-1:0] shreg;

    bit_sync #(
        .RST_VAL(BUS_IDLE)
    ) u_sync (
        .clk  (Clk),
        .rst_n(Rst_n),
        .d    (BusLine),
        .q    (line_s)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            Data     <= '0;
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
            // A load in STOP below overrides this consume.
            if (Valid && Ready)
                Valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (line_s == BUS_START) begin
                        state <= START;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (line_s == BUS_START) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {~line_s, shreg[DATA_W-1:1]};
                        if (bit_idx == LAST_IDX)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (line_s == BUS_IDLE) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                            if (!Valid || Ready) begin
                                Data  <= shreg;
                                Valid <= 1'b1;
                            end else begin
                                Overrun <= 1'b1;
                            end
                        end else begin
                            FrameErr <= 1'b1;
                            state    <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (line_s == BUS_IDLE) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_bus_rx.sv
// Self-checking bench for inv_bus_rx: directed frame table, hand-written corner
// sequences and randomized frames scored against an abstract holding-slot model.
module tb_inv_bus_rx;

    localparam int unsigned CPB = 16;
    // Edge of the stop-bit sample, counted from the edge before the start bit is
    // driven: 2 sync flops + 1 detect edge + half bit + 8 data bits + 1 stop bit.
    localparam int unsigned LOAD_EDGE = 3 + CPB / 2 + 8 * CPB + CPB;

    logic       clk;
    logic       rst_n;
    logic       bus_line;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    inv_bus_rx #(
        .DATA_W      (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .BusLine (bus_line),
        .Data    (data),
        .Valid   (valid),
        .Ready   (ready),
        .FrameErr(frame_err),
        .Overrun (overrun),
        .Busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  got_q[$];
    int unsigned n_ferr = 0;
    int unsigned n_ovr  = 0;
    int unsigned n_viol = 0;
    logic        hold_prev = 1'b0;
    logic [7:0]  data_prev = '0;

    // Handshakes seen at the falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) got_q.push_back(data);
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (frame_err && overrun) n_viol++;
            if (hold_prev && data != data_prev) n_viol++;
            hold_prev = valid && !ready;
            data_prev = data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input logic stop_lvl,
                              output logic busy_brk, output logic busy_after);
        bus_line = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus_line = ~w[i];
            tick(CPB);
        end
        bus_line = stop_lvl;
        tick(CPB);
        busy_brk   = busy;
        busy_after = busy;
        if (!stop_lvl) begin
            tick(24);
            busy_brk = busy;
            bus_line = 1'b1;
            tick(6);
            busy_after = busy;
        end
    endtask

    typedef struct {
        logic [7:0]  word;
        logic        stop;
        logic        rdy;
        int unsigned n_deliv;
        logic [7:0]  exp_word;
        int unsigned n_ferr;
        int unsigned n_ovr;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int unsigned q0, f0, o0;
        logic        bb, ba, saw_busy, full_m, r;
        logic [7:0]  w;
        logic [7:0]  exp_q[$];
        int unsigned exp_ferr, exp_ovr, kind, n;

        vecs[0] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 0, 0, 1'b0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 0, 0, 1'b0, 8'hFF};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 0, 0, 1'b0, 8'hA5};
        vecs[3] = '{8'h0F, 1'b0, 1'b1, 0, 8'h00, 1, 0, 1'b0, 8'hA5};
        vecs[4] = '{8'h3C, 1'b1, 1'b0, 0, 8'h00, 0, 0, 1'b1, 8'h3C};
        vecs[5] = '{8'hC3, 1'b1, 1'b0, 0, 8'h00, 0, 1, 1'b1, 8'h3C};

        rst_n    = 1'b0;
        bus_line = 1'b1;
        ready    = 1'b0;
        tick(3);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(5);

        foreach (vecs[i]) begin
            ready = vecs[i].rdy;
            q0 = got_q.size();
            f0 = n_ferr;
            o0 = n_ovr;
            send_frame(vecs[i].word, vecs[i].stop, bb, ba);
            tick(8);
            check($sformatf("vec%0d_deliv", i), got_q.size() - q0, vecs[i].n_deliv);
            if (vecs[i].n_deliv > 0 && got_q.size() > 0)
                check($sformatf("vec%0d_word", i), got_q[got_q.size()-1], vecs[i].exp_word);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].n_ferr);
            check($sformatf("vec%0d_ovr", i), n_ovr - o0, vecs[i].n_ovr);
            check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            if (!vecs[i].stop) begin
                check($sformatf("vec%0d_busy_brk", i), bb, 1'b1);
                check($sformatf("vec%0d_busy_idle", i), ba, 1'b0);
            end
        end

        // Held word released by Ready: Valid drops next cycle, Data unchanged.
        q0 = got_q.size();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("drain_valid", valid, 1'b0);
        check("drain_data", data, 8'h3C);
        check("drain_deliv", got_q.size() - q0, 1);
        if (got_q.size() > 0) check("drain_word", got_q[got_q.size()-1], 8'h3C);
        tick(4);

        // Start glitch: short low pulse must not frame anything.
        ready = 1'b1;
        q0 = got_q.size();
        f0 = n_ferr;
        saw_busy = 1'b0;
        bus_line = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (busy) saw_busy = 1'b1;
        end
        bus_line = 1'b1;
        n = 0;
        while (busy && n < 12) begin
            tick(1);
            n++;
        end
        check("glitch_busy_seen", saw_busy, 1'b1);
        check("glitch_busy_idle", busy, 1'b0);
        tick(20);
        check("glitch_deliv", got_q.size() - q0, 0);
        check("glitch_ferr", n_ferr - f0, 0);

        // Ready asserted only in the load cycle of a frame arriving onto a full slot.
        ready = 1'b0;
        send_frame(8'h3C, 1'b1, bb, ba);
        tick(8);
        q0 = got_q.size();
        o0 = n_ovr;
        fork
            send_frame(8'hC3, 1'b1, bb, ba);
            begin
                tick(LOAD_EDGE - 1);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        tick(8);
        check("pulse_valid", valid, 1'b1);
        check("pulse_data", data, 8'hC3);
        check("pulse_ovr", n_ovr - o0, 0);
        check("pulse_deliv", got_q.size() - q0, 1);
        if (got_q.size() > q0) check("pulse_word", got_q[q0], 8'h3C);
        ready = 1'b1;
        tick(4);

        // Reset in the middle of a frame while a word is held.
        ready = 1'b0;
        send_frame(8'h81, 1'b1, bb, ba);
        tick(8);
        check("prerst_valid", valid, 1'b1);
        w = 8'h96;
        bus_line = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            bus_line = ~w[i];
            tick(CPB);
        end
        tick(CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_valid", valid, 1'b0);
        check("midrst_ferr", frame_err, 1'b0);
        check("midrst_ovr", overrun, 1'b0);
        check("midrst_busy", busy, 1'b0);
        bus_line = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        ready = 1'b1;
        q0 = got_q.size();
        f0 = n_ferr;
        o0 = n_ovr;
        send_frame(8'h5A, 1'b1, bb, ba);
        tick(8);
        check("postrst_deliv", got_q.size() - q0, 1);
        if (got_q.size() > q0) check("postrst_word", got_q[q0], 8'h5A);
        check("postrst_ferr", n_ferr - f0, 0);
        check("postrst_ovr", n_ovr - o0, 0);

        // Random frames against a one-slot model with Ready held per frame.
        tick(4);
        got_q.delete();
        f0 = n_ferr;
        o0 = n_ovr;
        exp_ferr = 0;
        exp_ovr = 0;
        full_m = 1'b0;
        for (int k = 0; k < 24; k++) begin
            r = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 5);
            w = 8'($urandom);
            ready = r;
            if (r) full_m = 1'b0;
            if (kind == 0) begin
                bus_line = 1'b0;
                tick(4);
                bus_line = 1'b1;
                tick(20);
            end else if (kind == 1) begin
                send_frame(w, 1'b0, bb, ba);
                exp_ferr++;
                tick(8);
            end else begin
                send_frame(w, 1'b1, bb, ba);
                tick(8);
                if (r) begin
                    exp_q.push_back(w);
                end else if (!full_m) begin
                    exp_q.push_back(w);
                    full_m = 1'b1;
                end else begin
                    exp_ovr++;
                end
            end
        end
        ready = 1'b1;
        tick(4);
        check("rnd_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rnd_word%0d", i), got_q[i], exp_q[i]);
        check("rnd_ferr", n_ferr - f0, exp_ferr);
        check("rnd_ovr", n_ovr - o0, exp_ovr);

        check("invariants", n_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
